// File: rtl/piano_key_encoder_if.sv
// piano_key_encoder_if: key/octave inputs and note outputs of the piano key encoder
interface piano_key_encoder_if #(
  parameter int NUM_KEYS = 8,
  parameter int NOTE_W = 6,
  parameter int OCT_W = 2
);
  logic [NUM_KEYS-1:0] sw;
  logic mode;
  logic oct_up;
  logic oct_down;
  logic gate;
  logic [NOTE_W-1:0] note;
  logic note_on;
  logic note_off;
  logic [OCT_W-1:0] octave;
  modport master(output sw, mode, oct_up, oct_down, input gate, note, note_on, note_off, octave);
  modport slave(input sw, mode, oct_up, oct_down, output gate, note, note_on, note_off, octave);
endinterface

// File: rtl/piano_key_encoder.sv
// piano_key_encoder: sync + debounce keys, pick one by priority mode, add octave, emit note/gate/strobes
module piano_key_encoder #(
  parameter int NUM_KEYS = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int OCT_MAX = 3,
  parameter int OCT_RESET = 1,
  parameter int NOTE_W = 6
) (
  input logic clk,
  input logic rst_n,
  piano_key_encoder_if.slave bus
);
  localparam int OCT_W = OCT_MAX > 0 ? $clog2(OCT_MAX + 1) : 1;
  localparam int IW = $clog2(NUM_KEYS);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [NUM_KEYS-1:0] s1, s2, db, db_next, rose;
  logic [CW-1:0] cnt [NUM_KEYS];
  logic [IW-1:0] last, sel;
  logic [NOTE_W-1:0] note_next;
  logic any;
  function automatic logic [IW-1:0] lowest(input logic [NUM_KEYS-1:0] v);
    lowest = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) if (v[i]) lowest = IW'(i);
  endfunction
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic done;
    assign done = s2[k] != db[k] && cnt[k] == CW'(DEBOUNCE_CYCLES - 1);
    assign db_next[k] = done ? s2[k] : db[k];
    always_ff @(posedge clk)
      cnt[k] <= (!rst_n || s2[k] == db[k] || done) ? '0 : cnt[k] + CW'(1);
  end
  assign rose = db_next & ~db;
  assign any = |db;
  // last-pressed only wins while that key is still held
  assign sel = bus.mode && db[last] ? last : lowest(db);
  assign note_next = any ? NOTE_W'(bus.octave) * NOTE_W'(NUM_KEYS) + NOTE_W'(sel) : bus.note;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      last <= '0;
      bus.octave <= OCT_W'(OCT_RESET);
      bus.gate <= 1'b0;
      bus.note <= '0;
      bus.note_on <= 1'b0;
      bus.note_off <= 1'b0;
    end else begin
      s1 <= bus.sw;
      s2 <= s1;
      db <= db_next;
      if (|rose) last <= lowest(rose);
      bus.octave <= (bus.oct_up && !bus.oct_down && bus.octave != OCT_W'(OCT_MAX)) ? bus.octave + OCT_W'(1) :
                    (bus.oct_down && !bus.oct_up && bus.octave != '0) ? bus.octave - OCT_W'(1) : bus.octave;
      bus.gate <= any;
      bus.note <= note_next;
      bus.note_on <= any && (!bus.gate || note_next != bus.note);
      bus.note_off <= !any && bus.gate;
    end
  end
endmodule
